i2c_slave_core: RTL
===================

# i2c_slave_core

I2C responder (slave) with a shared byte memory, for boards where the FPGA is addressed by an external I2C master. It oversamples SCL/SDA on the bus clock, decodes START/STOP, and matches a programmable 7-bit address. Master writes land in the memory and master reads are served from it. The basil register bus reads and writes the same memory and a small status/control register file.

## Interface
- ABUSWIDTH, 16: width of BUS_ADD.
- MEM_BYTES, 16: shared memory depth in bytes (1..65535), mapped at bus addresses 8..8+MEM_BYTES-1.
- VERSION (localparam), 1: value read at bus address 0.
- BUS_CLK  in  1  sole clock; sampling clock for SCL/SDA, must be ≥ 16× SCL frequency.
- BUS_RST_N  in  1  reset, asynchronous, active-low.
- BUS_ADD  in  ABUSWIDTH  register/memory address.
- BUS_DATA_IN  in  8  write data.
- BUS_RD  in  1  read strobe.
- BUS_WR  in  1  write strobe.
- BUS_DATA_OUT  out  8  read data, valid the cycle after BUS_RD; reset 0.
- I2C_SCL  in  1  SCL line; never driven, no clock stretching.
- I2C_SDA  inout  1  open-drain: drives 0 or z; released (z) at reset.

## Operation
- Register map:
  - 0: write = soft reset (FSM, status, counters; memory untouched); read = VERSION.
  - 1: status, read-only fields, any write clears bits 3:1. bit0 BUSY (addressed transaction in progress), bit1 WR_DONE, bit2 RD_DONE, bit3 OVERFLOW.
  - 2: OWN_ADDR in bits [6:0]; reset 0x00.
  - 3/4: RX_COUNT low/high, the number of bytes accepted in the last write transaction; read-only.
  - 5/6: MEM_BYTES low/high.
- Line conditioning: each line passes through a 2-FF synchronizer, then edge detection on the synchronized copy.
- Bus conditions:
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - A START or STOP in any state aborts the current byte.
  - A START, including a repeated START, goes to ADDR with bit_cnt=0 and ptr=0.
  - A STOP goes to IDLE.
- Data sampling: data bits are sampled on the SCL rising edge, MSB first. SDA output changes only on the SCL falling edge.
- FSM states: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
  - ADDR: shift 8 bits. On [7:1]==OWN_ADDR, go to ADDR_ACK and drive SDA=0 for the 9th clock. Otherwise go to IGNORE (released until the next START or STOP).
  - After ADDR_ACK, the R/W bit selects the next state: 0 → WR_DATA, 1 → RD_DATA. For RD_DATA, mem[0] is loaded into the shift register.
  - WR_DATA: after 8 bits, if ptr<MEM_BYTES, write mem[ptr], increment ptr and RX_COUNT, and ACK. Otherwise NACK (SDA released), set OVERFLOW, and write nothing.
  - RD_DATA: drive 8 bits, then release SDA and sample the master's ACK on the 9th rising edge.
    - ACK: ptr increments, wrapping to 0 after MEM_BYTES-1, then mem[ptr] is loaded and the FSM returns to RD_DATA.
    - NACK: go to IGNORE.
- Completion flags at STOP:
  - WR_DONE is set if the transaction was a write with RX_COUNT>0.
  - RD_DONE is set if at least one byte was sent.
- RX_COUNT is cleared at the ACK of a matching write address.
- Memory arbitration: bus writes to memory are ignored while BUSY=1. Bus reads are always served.

## Timing
- Reset values: BUS_DATA_OUT=0, SDA released, FSM=IDLE, all status bits 0, RX_COUNT=0, OWN_ADDR=0.
- Pin-to-internal latency: 3 BUS_CLK from a pin change to the detected edge (2 synchronizer cycles + 1 edge register).
- SDA drive timing:
  - Drive/release happens 1 BUS_CLK after the detected SCL fall.
  - This gives an SDA hold of at least 4 BUS_CLK after the SCL pin falls.
- Reset mid-transfer: SDA is released immediately (asynchronous), and a new START is required afterwards.
- Simultaneous events: a START and a STOP detected in the same cycle cannot occur, because SDA changes once. A soft reset in the same cycle as an I2C event takes priority.
- WR_DONE/RD_DONE: set 1 cycle after the STOP is detected. If a status clear (write to address 1) hits the same cycle, the set wins.

## Configuration
- I2C_SLAVE_GLITCH_FILTER_EN:
  - Defined: after the synchronizers, each line changes its filtered value only after 3 consecutive equal samples. This suppresses pulses of 2 BUS_CLK or less and adds 2 cycles of latency (total 5).
  - Undefined: no filter; latency is 3.

## Test plan
- Write: OWN_ADDR=0x50; master sends START, 0xA0, 0x11, 0x22, 0x33, STOP.
  - Every byte is ACKed.
  - mem[0..2] = 11, 22, 33; RX_COUNT=3; status=0x02.
- Read: mem[0..1] = 0xAB, 0xCD; master sends START, 0xA1, reads 2 bytes (ACK, then NACK), STOP.
  - Master receives AB, CD.
  - status=0x04; SDA released after the NACK.
- Address mismatch: master sends START, 0xA2, 0x55, STOP.
  - SDA is never driven low.
  - mem is unchanged; status=0x00.
- Overflow and repeated START: MEM_BYTES=2; master writes 3 bytes.
  - 3rd byte is NACKed; OVERFLOW=1; RX_COUNT=2.
  - Repeated START 0xA1 then returns mem[0].
- Reset mid-transfer: BUS_RST_N asserted during RD_DATA while SDA=0.
  - SDA releases with no clock edge.
  - FSM=IDLE, BUSY=0.
  - Next START 0xA0 is ACKed.
- Glitch filter, with I2C_SLAVE_GLITCH_FILTER_EN defined: a 2-cycle low pulse on SDA while SCL is high.
  - No START is detected and the FSM stays in IDLE.
  - Without the macro, the FSM enters ADDR.

Source files
------------

// File: rtl/i2c_slave_core.sv
// i2c_slave_core: I2C responder (slave) with a shared byte memory that is also
// reachable from the basil register bus. SCL/SDA are oversampled on BUS_CLK.
// Optional build macro: I2C_SLAVE_GLITCH_FILTER_EN adds a 3-sample glitch
// filter behind the synchronizers (2 extra cycles of line latency).
module i2c_slave_core #(
   parameter int ABUSWIDTH = 16,
   parameter int MEM_BYTES = 16
) (
   input  logic                 BUS_CLK,
   input  logic                 BUS_RST_N,
   input  logic [ABUSWIDTH-1:0] BUS_ADD,
   input  logic [7:0]           BUS_DATA_IN,
   input  logic                 BUS_RD,
   input  logic                 BUS_WR,
   output logic [7:0]           BUS_DATA_OUT,
   input  logic                 I2C_SCL,
   inout  wire                  I2C_SDA
);

   localparam logic [7:0]  VERSION     = 8'd1;
   localparam int          AW          = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
   localparam logic [16:0] MEM_SIZE    = 17'(MEM_BYTES);
   localparam logic [16:0] MEM_LAST    = 17'(MEM_BYTES - 1);
   localparam logic [15:0] MEM_BYTES16 = 16'(MEM_BYTES);

   typedef enum logic [2:0] {
      IDLE = 3'd0, ADDR = 3'd1, ADDR_ACK = 3'd2, WR_DATA = 3'd3,
      WR_ACK = 3'd4, RD_DATA = 3'd5, RD_ACK = 3'd6, IGNORE = 3'd7
   } state_t;

   logic [1:0]  scl_sync_q, sda_sync_q;
   logic        scl_l, sda_l;
   logic        scl_p_q, sda_p_q;
   logic        scl_rise_s, scl_fall_s, start_s, stop_s;
   state_t      state_q;
   logic [3:0]  bit_cnt_q;
   logic [7:0]  sr_q;
   logic [16:0] ptr_q, ptr_wrap_d;
   logic [15:0] rx_cnt_q;
   logic        sda_oe_q, rw_q, ack_phase_q, ack_ok_q, wr_txn_q, rd_sent_q;
   logic        busy_q, wr_done_q, rd_done_q, ovf_q;
   logic [6:0]  own_addr_q;
   logic [7:0]  mem_q [0:MEM_BYTES-1];
   logic [7:0]  rx_byte_s, mem_rd_s, rd_data_s;
   logic [31:0] bus_add32_s, mem_idx_s;
   logic        mem_hit_s, srst_s, clr_s, mem_wr_s, unused_s;

   // Open-drain SDA: only ever pull low or release.
   assign I2C_SDA = sda_oe_q ? 1'b0 : 1'bz;

   // Two-flop synchronizers for both bus lines (idle bus level is high).
   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         scl_sync_q <= 2'b11;
         sda_sync_q <= 2'b11;
      end else begin
         scl_sync_q <= {scl_sync_q[0], I2C_SCL};
         sda_sync_q <= {sda_sync_q[0], I2C_SDA};
      end
   end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
   logic [1:0] scl_hist_q, sda_hist_q;
   logic       scl_hold_q, sda_hold_q;

   // Sample history and last accepted level of each line for the filter.
   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         scl_hist_q <= 2'b11;
         sda_hist_q <= 2'b11;
         scl_hold_q <= 1'b1;
         sda_hold_q <= 1'b1;
      end else begin
         scl_hist_q <= {scl_hist_q[0], scl_sync_q[1]};
         sda_hist_q <= {sda_hist_q[0], sda_sync_q[1]};
         scl_hold_q <= scl_l;
         sda_hold_q <= sda_l;
      end
   end

   // A line takes a new level only after three consecutive equal samples.
   always_comb begin
      scl_l = scl_hold_q;
      sda_l = sda_hold_q;
      if ((scl_sync_q[1] == scl_hist_q[0]) && (scl_hist_q[0] == scl_hist_q[1])) begin
         scl_l = scl_sync_q[1];
      end else begin
         scl_l = scl_hold_q;
      end
      if ((sda_sync_q[1] == sda_hist_q[0]) && (sda_hist_q[0] == sda_hist_q[1])) begin
         sda_l = sda_sync_q[1];
      end else begin
         sda_l = sda_hold_q;
      end
   end
`else
   assign scl_l = scl_sync_q[1];
   assign sda_l = sda_sync_q[1];
`endif

   // Previous conditioned line levels, used for edge and condition detection.
   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         scl_p_q <= 1'b1;
         sda_p_q <= 1'b1;
      end else begin
         scl_p_q <= scl_l;
         sda_p_q <= sda_l;
      end
   end

   assign scl_rise_s = scl_l & ~scl_p_q;
   assign scl_fall_s = ~scl_l & scl_p_q;
   assign start_s    = scl_l & scl_p_q & sda_p_q & ~sda_l;
   assign stop_s     = scl_l & scl_p_q & ~sda_p_q & sda_l;

   assign bus_add32_s = 32'(BUS_ADD);
   assign mem_hit_s   = (bus_add32_s >= 32'd8) && (bus_add32_s < (32'(MEM_BYTES) + 32'd8));
   assign mem_idx_s   = bus_add32_s - 32'd8;
   assign srst_s      = BUS_WR && (bus_add32_s == 32'd0);
   assign clr_s       = BUS_WR && (bus_add32_s == 32'd1);
   assign rx_byte_s   = {sr_q[6:0], sda_l};
   assign mem_rd_s    = mem_q[ptr_q[AW-1:0]];
   assign ptr_wrap_d  = (ptr_q >= MEM_LAST) ? 17'd0 : (ptr_q + 17'd1);
   assign mem_wr_s    = (state_q == WR_DATA) && scl_rise_s && (bit_cnt_q == 4'd7) &&
                        (ptr_q < MEM_SIZE) && !srst_s;
   assign unused_s    = ^{mem_idx_s[31:AW], sr_q[7]};

   // Protocol FSM plus transfer counters and status flags; soft reset wins over bus events.
   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         state_q <= IDLE; bit_cnt_q <= 4'd0; sr_q <= 8'h00; ptr_q <= 17'd0;
         rx_cnt_q <= 16'd0; sda_oe_q <= 1'b0; rw_q <= 1'b0; ack_phase_q <= 1'b0;
         ack_ok_q <= 1'b0; wr_txn_q <= 1'b0; rd_sent_q <= 1'b0; busy_q <= 1'b0;
         wr_done_q <= 1'b0; rd_done_q <= 1'b0; ovf_q <= 1'b0;
      end else if (srst_s) begin
         state_q <= IDLE; bit_cnt_q <= 4'd0; sr_q <= 8'h00; ptr_q <= 17'd0;
         rx_cnt_q <= 16'd0; sda_oe_q <= 1'b0; rw_q <= 1'b0; ack_phase_q <= 1'b0;
         ack_ok_q <= 1'b0; wr_txn_q <= 1'b0; rd_sent_q <= 1'b0; busy_q <= 1'b0;
         wr_done_q <= 1'b0; rd_done_q <= 1'b0; ovf_q <= 1'b0;
      end else begin
         if (clr_s) begin
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
            ovf_q     <= 1'b0;
         end
         if (start_s) begin
            state_q     <= ADDR;
            bit_cnt_q   <= 4'd0;
            ptr_q       <= 17'd0;
            sda_oe_q    <= 1'b0;
            ack_phase_q <= 1'b0;
         end else if (stop_s) begin
            state_q   <= IDLE;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_txn_q  <= 1'b0;
            rd_sent_q <= 1'b0;
            if (wr_txn_q && (rx_cnt_q != 16'd0)) wr_done_q <= 1'b1;
            if (rd_sent_q) rd_done_q <= 1'b1;
         end else begin
            case (state_q)
               IDLE: sda_oe_q <= 1'b0;
               ADDR: begin
                  if (scl_rise_s) begin
                     sr_q      <= rx_byte_s;
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                     if (bit_cnt_q == 4'd7) begin
                        if (rx_byte_s[7:1] == own_addr_q) begin
                           state_q     <= ADDR_ACK;
                           rw_q        <= rx_byte_s[0];
                           ack_phase_q <= 1'b0;
                           busy_q      <= 1'b1;
                        end else begin
                           state_q <= IGNORE;
                        end
                     end
                  end
               end
               ADDR_ACK: begin
                  if (scl_fall_s) begin
                     if (!ack_phase_q) begin
                        sda_oe_q <= 1'b1;
                     end else begin
                        bit_cnt_q <= 4'd0;
                        if (rw_q) begin
                           state_q  <= RD_DATA;
                           sr_q     <= mem_rd_s;
                           sda_oe_q <= ~mem_rd_s[7];
                        end else begin
                           state_q  <= WR_DATA;
                           sda_oe_q <= 1'b0;
                        end
                     end
                  end else if (scl_rise_s) begin
                     ack_phase_q <= 1'b1;
                     if (!rw_q) begin
                        rx_cnt_q <= 16'd0;
                        wr_txn_q <= 1'b1;
                     end
                  end
               end
               WR_DATA: begin
                  if (scl_rise_s) begin
                     sr_q      <= rx_byte_s;
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                     if (bit_cnt_q == 4'd7) begin
                        state_q     <= WR_ACK;
                        ack_phase_q <= 1'b0;
                        if (ptr_q < MEM_SIZE) begin
                           ptr_q    <= ptr_q + 17'd1;
                           rx_cnt_q <= rx_cnt_q + 16'd1;
                           ack_ok_q <= 1'b1;
                        end else begin
                           ack_ok_q <= 1'b0;
                           ovf_q    <= 1'b1;
                        end
                     end
                  end
               end
               WR_ACK: begin
                  if (scl_fall_s) begin
                     if (!ack_phase_q) begin
                        sda_oe_q <= ack_ok_q;
                     end else begin
                        sda_oe_q  <= 1'b0;
                        bit_cnt_q <= 4'd0;
                        state_q   <= WR_DATA;
                     end
                  end else if (scl_rise_s) begin
                     ack_phase_q <= 1'b1;
                  end
               end
               RD_DATA: begin
                  if (scl_rise_s) begin
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end else if (scl_fall_s) begin
                     if (bit_cnt_q == 4'd8) begin
                        sda_oe_q    <= 1'b0;
                        state_q     <= RD_ACK;
                        ack_phase_q <= 1'b0;
                        rd_sent_q   <= 1'b1;
                     end else begin
                        sr_q     <= {sr_q[6:0], 1'b0};
                        sda_oe_q <= ~sr_q[6];
                     end
                  end
               end
               RD_ACK: begin
                  if (scl_rise_s) begin
                     if (!sda_l) begin
                        ptr_q       <= ptr_wrap_d;
                        ack_phase_q <= 1'b1;
                     end else begin
                        state_q <= IGNORE;
                     end
                  end else if (scl_fall_s && ack_phase_q) begin
                     sr_q      <= mem_rd_s;
                     sda_oe_q  <= ~mem_rd_s[7];
                     bit_cnt_q <= 4'd0;
                     state_q   <= RD_DATA;
                  end
               end
               IGNORE: sda_oe_q <= 1'b0;
               default: begin
                  state_q  <= IDLE;
                  sda_oe_q <= 1'b0;
               end
            endcase
         end
      end
   end

   // Own slave address register.
   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         own_addr_q <= 7'h00;
      end else if (BUS_WR && (bus_add32_s == 32'd2)) begin
         own_addr_q <= BUS_DATA_IN[6:0];
      end
   end

   // Shared memory: I2C writes first, bus writes only while no transaction is addressed.
   always_ff @(posedge BUS_CLK) begin
      if (mem_wr_s) begin
         mem_q[ptr_q[AW-1:0]] <= rx_byte_s;
      end else if (BUS_WR && mem_hit_s && !busy_q) begin
         mem_q[mem_idx_s[AW-1:0]] <= BUS_DATA_IN;
      end
   end

   // Register/memory read multiplexer.
   always_comb begin
      rd_data_s = 8'h00;
      if (mem_hit_s) begin
         rd_data_s = mem_q[mem_idx_s[AW-1:0]];
      end else begin
         case (bus_add32_s)
            32'd0:   rd_data_s = VERSION;
            32'd1:   rd_data_s = {4'b0000, ovf_q, rd_done_q, wr_done_q, busy_q};
            32'd2:   rd_data_s = {1'b0, own_addr_q};
            32'd3:   rd_data_s = rx_cnt_q[7:0];
            32'd4:   rd_data_s = rx_cnt_q[15:8];
            32'd5:   rd_data_s = MEM_BYTES16[7:0];
            32'd6:   rd_data_s = MEM_BYTES16[15:8];
            default: rd_data_s = 8'h00;
         endcase
      end
   end

   // Registered read data, valid the cycle after the read strobe.
   always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
      if (!BUS_RST_N) begin
         BUS_DATA_OUT <= 8'h00;
      end else if (BUS_RD) begin
         BUS_DATA_OUT <= rd_data_s;
      end
   end

endmodule
